// File: rtl/counter_cmd_pkg.sv
// Shared encodings for the counter command sequencer and its reference model.
package counter_cmd_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_INC = 2'b01;
   localparam logic [1:0] OP_DEC = 2'b10;
   localparam logic [1:0] OP_INV = 2'b11;

   localparam logic [1:0] REQ_LOAD   = 2'b00;
   localparam logic [1:0] REQ_UP     = 2'b01;
   localparam logic [1:0] REQ_DOWN   = 2'b10;
   localparam logic [1:0] REQ_INVERT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_CHECK = 2'b10
   } state_t;

   // Counter opcode issued for a request kind; LOAD uses the set strobe instead.
   function automatic logic [1:0] kind_to_op(input logic [1:0] kind);
      logic [1:0] code;
      code = OP_NOP;
      case (kind)
         REQ_UP:     code = OP_INC;
         REQ_DOWN:   code = OP_DEC;
         REQ_INVERT: code = OP_INV;
         default:    code = OP_NOP;
      endcase
      return code;
   endfunction

   // UP/DOWN requests carry a step count rather than a value.
   function automatic logic is_step(input logic [1:0] kind);
      return (kind == REQ_UP) || (kind == REQ_DOWN);
   endfunction

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Request handshake between the requester and the command sequencer.
interface counter_cmd_seq_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_kind;
   logic [WIDTH-1:0] req_data;

   modport master (
      output req_valid,
      output req_kind,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_kind,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/counter_ref_model.sv
// Reference model of the load/inc/dec/invert counter: {carry, out} register.
module counter_ref_model
   import counter_cmd_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [WIDTH-1:0] load,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] out,
   output logic             carry
);

   localparam int unsigned CW = WIDTH + 1;

   // Load has priority; inc/dec wrap over the full carry+out width.
   always_ff @(posedge clk) begin
      if (rst) begin
         out   <= '0;
         carry <= 1'b0;
      end else if (set) begin
         out   <= load;
         carry <= 1'b0;
      end else begin
         case (op)
            OP_INC:  {carry, out} <= {carry, out} + CW'(1);
            OP_DEC:  {carry, out} <= {carry, out} - CW'(1);
            OP_INV:  out <= ~out;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer: turns requests into counter control cycles and checks
// the counter against the reference model after every request.
module counter_cmd_seq
   import counter_cmd_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   counter_cmd_seq_if.slave req,
   output logic             set,
   output logic [WIDTH-1:0] load,
   output logic [1:0]       op,
   input  logic [WIDTH-1:0] cnt_out,
   input  logic             cnt_carry,
   output logic [WIDTH-1:0] exp_out,
   output logic             exp_carry,
   output logic             done,
   output logic             mismatch
);

   state_t           state;
   logic [WIDTH-1:0] remaining;

   // Sequencer FSM with registered command, handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         remaining     <= '0;
         req.req_ready <= 1'b1;
         set           <= 1'b0;
         load          <= '0;
         op            <= OP_NOP;
         done          <= 1'b0;
         mismatch      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req.req_valid) begin
                  req.req_ready <= 1'b0;
                  if (is_step(req.req_kind) && (req.req_data == '0)) begin
                     state <= ST_CHECK;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_ISSUE;
                     remaining <= is_step(req.req_kind) ? req.req_data : WIDTH'(1);
                     set       <= (req.req_kind == REQ_LOAD);
                     load      <= (req.req_kind == REQ_LOAD) ? req.req_data : '0;
                     op        <= kind_to_op(req.req_kind);
                  end
               end
            end
            ST_ISSUE: begin
               remaining <= remaining - WIDTH'(1);
               if (remaining == WIDTH'(1)) begin
                  state <= ST_CHECK;
                  set   <= 1'b0;
                  load  <= '0;
                  op    <= OP_NOP;
                  done  <= 1'b1;
               end
            end
            ST_CHECK: begin
               if ({cnt_carry, cnt_out} != {exp_carry, exp_out}) begin
                  mismatch <= 1'b1;
               end
               state         <= ST_IDLE;
               req.req_ready <= 1'b1;
            end
            default: begin
               state         <= ST_IDLE;
               req.req_ready <= 1'b1;
            end
         endcase
      end
   end

   counter_ref_model #(.WIDTH(WIDTH)) u_model (
      .clk   (clk),
      .rst   (rst),
      .set   (set),
      .load  (load),
      .op    (op),
      .out   (exp_out),
      .carry (exp_carry)
   );

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Scoreboard bench for counter_cmd_seq driving a behavioural 4-bit counter.
module tb_counter_cmd_seq;
   import counter_cmd_pkg::*;

   logic       clk;
   logic       rst;
   logic       set;
   logic [3:0] load;
   logic [1:0] op;
   logic [3:0] cnt_out;
   logic       cnt_carry;
   logic [3:0] exp_out;
   logic       exp_carry;
   logic       done;
   logic       mismatch;
   logic       stuck;
   logic [4:0] cc;
   int         cyc;
   int         vectors;
   int         miscompares;
   int         ncmd;
   bit         mism_pending;
   logic       mism_exp;

   typedef struct {
      logic [4:0] exp_model;
      logic [4:0] exp_cnt;
      int         due;
      int         ncmd;
      logic       mism;
   } item_t;

   item_t q[$];

   counter_cmd_seq_if #(.WIDTH(4)) bus ();

   counter_cmd_seq #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (bus),
      .set       (set),
      .load      (load),
      .op        (op),
      .cnt_out   (cnt_out),
      .cnt_carry (cnt_carry),
      .exp_out   (exp_out),
      .exp_carry (exp_carry),
      .done      (done),
      .mismatch  (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // The counter under control, with an optional stuck-at-zero output fault.
   always @(posedge clk) begin
      if (rst)                cc <= 5'd0;
      else if (set)           cc <= {1'b0, load};
      else if (op == 2'b01)   cc <= (cc == 5'd31) ? 5'd0  : cc + 5'd1;
      else if (op == 2'b10)   cc <= (cc == 5'd0)  ? 5'd31 : cc - 5'd1;
      else if (op == 2'b11)   cc <= {cc[4], ~cc[3:0]};
   end
   assign cnt_out   = stuck ? 4'b0000 : cc[3:0];
   assign cnt_carry = cc[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one request; returns #1 after the accepting edge.
   task automatic send(input logic [1:0] kind, input logic [3:0] data,
                       input logic [4:0] em, input logic [4:0] ec,
                       input int m, input logic mism, input bit push);
      item_t it;
      int    w;
      w = 0;
      @(negedge clk);
      while (!bus.req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) begin
         chk("ready_timeout", 32'(bus.req_ready), 1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_kind  = kind;
      bus.req_data  = data;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (push) begin
         it.exp_model = em;
         it.exp_cnt   = ec;
         it.due       = cyc + m;
         it.ncmd      = m;
         it.mism      = mism;
         q.push_back(it);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((q.size() != 0 || mism_pending) && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
   endtask

   // Monitor: pops the scoreboard whenever the sequencer signals done.
   always @(negedge clk) begin : mon
      item_t it;
      if (rst) begin
         ncmd         = 0;
         mism_pending = 1'b0;
      end else begin
         if (mism_pending) begin
            chk("mismatch_after", 32'(mismatch), 32'(mism_exp));
            mism_pending = 1'b0;
         end
         if (set || op != OP_NOP) ncmd++;
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(done), 0);
            end else begin
               it = q.pop_front();
               chk("done_cycle", cyc, it.due);
               chk("model", 32'({exp_carry, exp_out}), 32'(it.exp_model));
               chk("counter", 32'({cnt_carry, cnt_out}), 32'(it.exp_cnt));
               chk("cmd_count", ncmd, it.ncmd);
               mism_exp     = it.mism;
               mism_pending = 1'b1;
            end
            ncmd = 0;
         end
      end
   end

   initial begin
      int nz;
      cyc           = 0;
      vectors       = 0;
      miscompares   = 0;
      ncmd          = 0;
      mism_pending  = 1'b0;
      mism_exp      = 1'b0;
      stuck         = 1'b0;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_kind  = 2'b00;
      bus.req_data  = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", 32'(bus.req_ready), 1);
      chk("reset_outs", 32'({set, load, op, done}), 0);
      chk("reset_model", 32'({exp_carry, exp_out}), 0);
      chk("reset_mismatch", 32'(mismatch), 0);

      send(REQ_LOAD, 4'b1110, 5'b0_1110, 5'b0_1110, 1, 1'b0, 1'b1);
      chk("load_strobe", 32'({set, load, op}), 32'({1'b1, 4'b1110, 2'b00}));
      send(REQ_UP, 4'd2, 5'b1_0000, 5'b1_0000, 2, 1'b0, 1'b1);
      chk("up_op", 32'(op), 32'(OP_INC));
      send(REQ_INVERT, 4'd0, 5'b1_1111, 5'b1_1111, 1, 1'b0, 1'b1);
      chk("inv_op", 32'(op), 32'(OP_INV));
      send(REQ_DOWN, 4'd2, 5'b1_1101, 5'b1_1101, 2, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("down_mid_model", 32'({exp_carry, exp_out}), 32'(5'b1_1110));
      send(REQ_UP, 4'd0, 5'b1_1101, 5'b1_1101, 0, 1'b0, 1'b1);
      chk("up0_no_op", 32'(op), 32'(OP_NOP));
      chk("up0_ready_low", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1;
      chk("up0_ready_back", 32'(bus.req_ready), 1);
      send(REQ_UP, 4'd3, 5'b0_0000, 5'b0_0000, 3, 1'b0, 1'b1);
      send(REQ_DOWN, 4'd1, 5'b1_1111, 5'b1_1111, 1, 1'b0, 1'b1);
      wait_idle();

      stuck = 1'b1;
      send(REQ_UP, 4'd3, 5'b0_0010, 5'b0_0000, 3, 1'b1, 1'b1);
      wait_idle();
      stuck = 1'b0;
      send(REQ_LOAD, 4'b0101, 5'b0_0101, 5'b0_0101, 1, 1'b1, 1'b1);
      wait_idle();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mismatch_cleared", 32'(mismatch), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      send(REQ_UP, 4'd5, 5'd0, 5'd0, 5, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("issue2_model", 32'({exp_carry, exp_out}), 32'(5'b0_0001));
      chk("issue2_op", 32'(op), 32'(OP_INC));
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.req_ready), 1);
      chk("rst_outs", 32'({set, load, op, done}), 0);
      chk("rst_model", 32'({exp_carry, exp_out}), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      nz = 0;
      repeat (8) begin
         @(negedge clk);
         if (op != OP_NOP || set || exp_out != 4'd0) nz++;
      end
      chk("no_inc_after_rst", nz, 0);

      wait_idle();
      chk("queue_drained", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
